cpu_ctrl_seq: RTL and testbench

Instruction-cycle sequencer for the RISC CPU: the consumer of the clock generator's fetch/phase timing. It steps an 8-state instruction cycle (S0–S7) whenever `ena` is high and decodes the current 3-bit opcode and the accumulator zero flag into registered control strobes. These strobes drive the PC, IR, accumulator, memory read/write and data-bus driver.

---
 rtl/cpu_ctrl_seq_if.sv | 30 +++
 rtl/cpu_ctrl_seq.sv | 78 +++++++
 tb/tb_cpu_ctrl_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_seq_if.sv
// cpu_ctrl_seq_if: sequencer bus bundle.
// The master side (clock generator / IR / accumulator) supplies the step enable,
// the opcode and the zero flag. The slave side (the sequencer) returns the
// registered control strobes and the debug state index.
interface cpu_ctrl_seq_if #(
    parameter int OPW = 3
);
    logic           ena;
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           inc_pc;
    logic           load_pc;
    logic           load_ir;
    logic           load_acc;
    logic           rd;
    logic           wr;
    logic           datactl_ena;
    logic           halt;
    logic [2:0]     state;

    modport master (
        output ena, opcode, zero,
        input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, state
    );

    modport slave (
        input  ena, opcode, zero,
        output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, state
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: 8-state instruction-cycle sequencer for the RISC CPU.
// Each enabled edge advances S0..S7 (wrapping). All strobes are registered and
// decoded from the state being entered, using the opcode and zero flag that are
// present at that edge.
// Optional build macro CTRL_STICKY_HALT_EN: HLT in S3 freezes the sequencer in
// S3 with halt held high until rst. Without it, halt is a one-state pulse.
module cpu_ctrl_seq #(
    parameter int OPW = 3
) (
    input  logic          clk,
    input  logic          rst,
    cpu_ctrl_seq_if.slave bus
);
    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    localparam logic [OPW-1:0] OP_HLT = 3'b000;
    localparam logic [OPW-1:0] OP_SKZ = 3'b001;
    localparam logic [OPW-1:0] OP_ADD = 3'b010;
    localparam logic [OPW-1:0] OP_AND = 3'b011;
    localparam logic [OPW-1:0] OP_XOR = 3'b100;
    localparam logic [OPW-1:0] OP_LDA = 3'b101;
    localparam logic [OPW-1:0] OP_STO = 3'b110;
    localparam logic [OPW-1:0] OP_JMP = 3'b111;

    // Strobe vector order: {halt, datactl_ena, wr, rd, load_acc, load_ir, load_pc, inc_pc}
    function automatic logic [7:0] decode(input state_t s, input logic [OPW-1:0] op,
                                          input logic z);
        logic alu;
        logic sto;
        logic jmp;
        logic skz;
        logic [7:0] v;
        alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        sto = (op == OP_STO);
        jmp = (op == OP_JMP);
        skz = (op == OP_SKZ) && z;
        v   = 8'b0;
        case (s)
            S0: v = 8'b0001_0100;
            S1: v = 8'b0001_0101;
            S2: v = 8'b0000_0000;
            S3: v = {(op == OP_HLT), 7'b000_0001};
            S4: v = {1'b0, sto, 1'b0, alu, 2'b00, jmp, 1'b0};
            S5: v = {1'b0, sto, sto, alu, alu, 1'b0, jmp, jmp | skz};
            S6: v = {1'b0, sto, 1'b0, alu, 4'b0000};
            S7: v = {7'b000_0000, skz};
            default: v = 8'b0;
        endcase
        return v;
    endfunction

    state_t st;
    state_t st_nxt;

    assign st_nxt    = state_t'(st + 3'd1);
    assign bus.state = st;

    // Sequencer state and registered control strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S7;
            {bus.halt, bus.datactl_ena, bus.wr, bus.rd,
             bus.load_acc, bus.load_ir, bus.load_pc, bus.inc_pc} <= 8'b0;
`ifdef CTRL_STICKY_HALT_EN
        end else if (bus.halt) begin
            // Frozen after HLT: hold S3, keep halt, drop every other strobe.
            st <= st;
            {bus.datactl_ena, bus.wr, bus.rd,
             bus.load_acc, bus.load_ir, bus.load_pc, bus.inc_pc} <= 7'b0;
`endif
        end else if (bus.ena) begin
            st <= st_nxt;
            {bus.halt, bus.datactl_ena, bus.wr, bus.rd,
             bus.load_acc, bus.load_ir, bus.load_pc, bus.inc_pc}
                <= decode(st_nxt, bus.opcode, bus.zero);
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: scoreboard bench for the instruction-cycle sequencer.
// Each driven edge pushes the expected {state, strobes} vector, which is popped
// and compared once the edge has happened.
module tb_cpu_ctrl_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [10:0] exp_q[$];
    logic [2:0]  m_state;
    logic [10:0] m_exp;
    bit          m_frozen;

    cpu_ctrl_seq_if bus ();

    cpu_ctrl_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] observed();
        return {bus.state, bus.halt, bus.datactl_ena, bus.wr, bus.rd,
                bus.load_acc, bus.load_ir, bus.load_pc, bus.inc_pc};
    endfunction

    // Reference: each strobe derived independently from state and opcode class.
    function automatic logic [10:0] model(input logic [2:0] s, input logic [2:0] op,
                                          input logic z);
        bit alu, sto, jmp, skz1;
        bit halt, dctl, wr, rd, lacc, lir, lpc, ipc;
        alu  = (op >= 3'd2) && (op <= 3'd5);
        sto  = (op == 3'd6);
        jmp  = (op == 3'd7);
        skz1 = (op == 3'd1) && z;
        rd   = (s == 3'd0) || (s == 3'd1) || (alu && (s >= 3'd4) && (s <= 3'd6));
        lir  = (s <= 3'd1);
        ipc  = (s == 3'd1) || (s == 3'd3) || (jmp && s == 3'd5) ||
               (skz1 && (s == 3'd5 || s == 3'd7));
        lpc  = jmp && (s == 3'd4 || s == 3'd5);
        lacc = alu && (s == 3'd5);
        wr   = sto && (s == 3'd5);
        dctl = sto && (s >= 3'd4) && (s <= 3'd6);
        halt = (op == 3'd0) && (s == 3'd3);
        return {s, halt, dctl, wr, rd, lacc, lir, lpc, ipc};
    endfunction

    task automatic compare_edge(input string tag);
        logic [10:0] obs;
        logic [10:0] e;
        obs = observed();
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {5'd0, obs}, {5'd0, e});
        end
        chk("inv_rd_wr", {15'd0, bus.rd & bus.wr}, 16'd0);
        chk("inv_wr_dctl", {15'd0, bus.wr & ~bus.datactl_ena}, 16'd0);
    endtask

    task automatic step(input string tag, input logic en, input logic [2:0] op,
                        input logic z);
        bus.ena    = en;
        bus.opcode = op;
        bus.zero   = z;
        if (m_frozen) begin
            m_exp = {3'd3, 8'h80};
        end else if (en) begin
            m_state = m_state + 3'd1;
            m_exp   = model(m_state, op, z);
`ifdef CTRL_STICKY_HALT_EN
            if (m_state == 3'd3 && op == 3'd0) m_frozen = 1'b1;
`endif
        end
        exp_q.push_back(m_exp);
        @(posedge clk);
        #1;
        compare_edge(tag);
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) step(tag, 1'b1, op, z);
    endtask

    // Assert rst a little after an edge with ena high; check the asynchronous
    // effect and that it still holds over an edge.
    task automatic do_reset();
        bus.ena = 1'b1;
        rst     = 1'b1;
        m_state  = 3'd7;
        m_exp    = {3'd7, 8'h00};
        m_frozen = 1'b0;
        #2;
        exp_q.push_back(m_exp);
        compare_edge("rst_async");
        exp_q.push_back(m_exp);
        @(posedge clk);
        #1;
        compare_edge("rst_edge");
        rst = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        bus.ena    = 1'b0;
        bus.opcode = 3'd0;
        bus.zero   = 1'b0;
        m_state    = 3'd7;
        m_exp      = 11'd0;
        m_frozen   = 1'b0;
        #1;
        do_reset();

        // first edge enters S0 (rd, load_ir), then LDA continues through S7
        run_instr("lda", 3'd5, 1'b0);
        run_instr("sto", 3'd6, 1'b0);
        run_instr("skz_z1", 3'd1, 1'b1);
        run_instr("skz_z0", 3'd1, 1'b0);
        run_instr("add", 3'd2, 1'b1);
        run_instr("and", 3'd3, 1'b0);
        run_instr("xor", 3'd4, 1'b0);

        // JMP with an ena gap at S4; opcode/zero wiggle during the gap
        for (int i = 0; i < 5; i++) step("jmp", 1'b1, 3'd7, 1'b0);
        step("jmp_gap", 1'b0, 3'd6, 1'b1);
        step("jmp_gap", 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) step("jmp", 1'b1, 3'd7, 1'b0);

        // gaps with random ena patterns across a whole STO and SKZ
        for (int i = 0; i < 24; i++)
            step("rand_ena", 1'($urandom_range(0, 1)), (i < 12) ? 3'd6 : 3'd1, 1'b1);
        while (m_state != 3'd7) step("rand_fill", 1'b1, 3'd2, 1'b0);

        // reset mid-instruction discards the partial instruction
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 3'd5, 1'b0);
        do_reset();
        run_instr("post_rst", 3'd6, 1'b0);

        // HLT
        for (int i = 0; i < 4; i++) step("hlt", 1'b1, 3'd0, 1'b0);
`ifdef CTRL_STICKY_HALT_EN
        for (int i = 0; i < 20; i++)
            step("hlt_frozen", 1'($urandom_range(0, 1)), 3'd2, 1'b1);
`else
        for (int i = 0; i < 5; i++) step("hlt_cont", 1'b1, 3'd0, 1'b0);
`endif
        do_reset();
        run_instr("after_hlt", 3'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
